shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_if.sv | 48 ++++
 rtl/shift_add_multiplier.sv | 133 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_if
//
// Purpose : bundles the operand/handshake/result signals exchanged between the
//           pushbutton/switch front end, the shift-and-add multiplier and the
//           result display stage.
//
// Signals : start   - single-cycle request pulse (front end -> multiplier)
//           a, b    - WIDTH-bit unsigned operands (front end -> multiplier)
//           product - 2*WIDTH-bit registered result (multiplier -> display)
//           busy    - operation in progress (RUN or DONE)
//           done    - one-cycle completion pulse
//           valid   - product holds a completed result
//
// Modports: master - drives start/a/b, observes the result side
//           slave  - the multiplier itself
// ---------------------------------------------------------------------------
interface shift_add_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;
    logic                 valid;

    modport master (
        output start,
        output a,
        output b,
        input  product,
        input  busy,
        input  done,
        input  valid
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output product,
        output busy,
        output done,
        output valid
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Purpose : sequential unsigned shift-and-add multiplier. An accepted start
//           pulse captures a and b, the block then runs exactly WIDTH
//           iterations (no early exit), publishes the 2*WIDTH-bit product and
//           pulses done for one cycle before returning to IDLE.
//
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous, active-high reset (priority over start)
//           bus  - shift_add_multiplier_if.slave
//                    start   in   pulse, only honoured in IDLE
//                    a, b    in   operands, captured on an accepted start
//                    product out  last completed product (registered)
//                    busy    out  high in RUN and DONE
//                    done    out  one-cycle pulse in DONE
//                    valid   out  set on completion, cleared on next start
//
// The WIDTH parameter must match the WIDTH of the connected interface.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_add_multiplier_if.slave  bus
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,   state_d;
    logic [PW-1:0]    mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [PW-1:0]    acc_q,     acc_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             valid_q,   valid_d;

    // Accumulator value after this cycle's conditional add; also the value
    // published as the product on the final iteration.
    logic [PW-1:0]    acc_sum;

    always_comb begin
        acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        valid_d   = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    mcand_d  = PW'(bus.a);
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    valid_d  = 1'b0;
                end
            end

            ST_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    product_d = acc_sum;
                    valid_d   = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe without any input-to-output path.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.valid   = valid_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Directed bench for shift_add_multiplier (WIDTH=8). A time-based reference
// model (countdown from an accepted start, product from plain a*b) is checked
// against every output on every falling edge; directed literal checks pin the
// expected numbers, latencies and done counts.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errs    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an accepted start begins a WIDTH+1 cycle window
    // (WIDTH RUN cycles then one DONE cycle). New starts are only accepted
    // once the window has fully elapsed.
    // ------------------------------------------------------------------
    int            rem      = 0;
    logic [PW-1:0] m_pend   = '0;
    logic [PW-1:0] m_prod   = '0;
    logic          m_valid  = 1'b0;
    int            m_dones  = 0;

    always @(posedge clk) begin
        if (rst) begin
            rem     = 0;
            m_pend  = '0;
            m_prod  = '0;
            m_valid = 1'b0;
        end else if (rem == 0) begin
            if (bus.start) begin
                m_pend  = PW'(bus.a) * PW'(bus.b);
                rem     = W + 1;
                m_valid = 1'b0;
            end
        end else begin
            rem = rem - 1;
            if (rem == 1) begin
                m_prod  = m_pend;
                m_valid = 1'b1;
                m_dones++;
            end
        end
    end

    bit chk_en    = 1'b0;
    int dut_dones = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model product", 32'(bus.product), 32'(m_prod));
            check("model busy",    32'(bus.busy),    32'(rem != 0));
            check("model done",    32'(bus.done),    32'(rem == 1));
            check("model valid",   32'(bus.valid),   32'(m_valid));
            if (bus.done === 1'b1) dut_dones++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all input changes happen at the falling edge)
    // ------------------------------------------------------------------
    // Returns in the cycle after the start was sampled (E0).
    task automatic op_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // lat counts the edges after E0 at which done became visible; called
    // while already "from" cycles past the cycle following E0.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (bus.done !== 1'b1 && lat < 4 * W) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [PW-1:0] exp);
        int lat;
        op_start(a, b);
        wait_done(0, lat);
        check({name, " latency"}, 32'(lat), W);
        check({name, " product"}, 32'(bus.product), 32'(exp));
        @(negedge clk);
        check({name, " done low after"},  32'(bus.done),  0);
        check({name, " busy low after"},  32'(bus.busy),  0);
        check({name, " valid held"},      32'(bus.valid), 1);
        check({name, " product held"},    32'(bus.product), 32'(exp));
    endtask

    initial begin
        int lat;
        int dones_before;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset product", 32'(bus.product), 0);
        check("reset busy",    32'(bus.busy),    0);
        check("reset done",    32'(bus.done),    0);
        check("reset valid",   32'(bus.valid),   0);
        rst = 1'b0;

        // Basic, maximum and zero operands
        run_op("13x11",   8'd13,  8'd11,  16'd143);
        run_op("255x255", 8'd255, 8'd255, 16'hFE01);
        run_op("0x200",   8'd0,   8'd200, 16'd0);

        // Restart attempt with new operands in RUN cycle 3 is ignored
        dones_before = dut_dones;
        op_start(8'd7, 8'd6);
        repeat (2) @(negedge clk);
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(3, lat);
        check("7x6 latency", 32'(lat), W);
        check("7x6 product", 32'(bus.product), 42);
        repeat (2 * W) @(negedge clk);
        check("7x6 single done", 32'(dut_dones - dones_before), 1);

        // Reset in RUN cycle 4 aborts without a done
        dones_before = dut_dones;
        op_start(8'd100, 8'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort product", 32'(bus.product), 0);
        check("abort busy",    32'(bus.busy),    0);
        check("abort done",    32'(bus.done),    0);
        check("abort valid",   32'(bus.valid),   0);
        repeat (2 * W) @(negedge clk);
        check("abort no done", 32'(dut_dones - dones_before), 0);
        run_op("100x3", 8'd100, 8'd3, 16'd300);

        // Back-to-back: start during DONE ignored, next IDLE edge accepted
        op_start(8'd5, 8'd5);
        wait_done(0, lat);
        check("5x5 latency", 32'(lat), W);
        check("5x5 product", 32'(bus.product), 25);
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        check("b2b idle busy",    32'(bus.busy),    0);
        check("b2b idle valid",   32'(bus.valid),   1);
        bus.a = 8'd3;
        bus.b = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b accept busy",    32'(bus.busy),    1);
        check("b2b accept valid",   32'(bus.valid),   0);
        check("b2b accept product", 32'(bus.product), 25);
        wait_done(0, lat);
        check("3x4 latency", 32'(lat), W);
        check("3x4 product", 32'(bus.product), 12);
        repeat (3) @(negedge clk);

        check("total dut dones",   32'(dut_dones), 7);
        check("total model dones", 32'(m_dones),   7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
